multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle sequencer for the MIPS datapath (addu, subu, ori, lw, sw, beq, jal): FETCH/DECODE/EXEC/MEM/WB
//  FSM sharing one ALU and one unified memory. Drives datapath muxes, PC/IR/RF write enables and a req/ready
//  memory handshake with timeout. OP/funct come from the IR output; Zero comes from the ALU.
// PARAMETERS
//  MEM_TIMEOUT  16  cycles FETCH/MEM may wait for mem_ready before bus error (>=2)
//  CNT_W        5   wait-counter width; must hold MEM_TIMEOUT
// PORTS
//  clk        in   1  clock, rising edge
//  reset      in   1  asynchronous, active-low reset
//  OP         in   6  IR[31:26]
//  funct      in   6  IR[5:0]
//  Zero       in   1  ALU zero flag
//  mem_ready  in   1  memory completed current read/write this cycle
//  PCWrite    out  1  PC load (uncond | Zero-qualified)
//  IRWrite    out  1  IR load
//  IorD       out  1  mem addr: 0 PC, 1 ALUOut
//  MemRead    out  1  memory read request
//  MemWrite   out  1  memory write request
//  RegWrite   out  1  register file write
//  RegDst     out  2  00 rt, 01 rd, 10 $31
//  Mem2Reg    out  2  RF data: 00 ALUOut, 01 MDR, 10 PC
//  ALUSrcA    out  1  0 PC, 1 rs
//  ALUSrcB    out  2  00 rt, 01 const 4, 10 ext imm, 11 sext imm<<2
//  ALUOp      out  2  00 ADDU, 01 SUBU, 10 OR
//  PCSource   out  2  00 ALU result, 01 ALUOut, 10 jump target
//  EXTOp      out  2  00 zero-ext, 01 sign-ext
//  state      out  3  FETCH0 DECODE1 EXEC2 MEM3 WB4 HALT5
//  bus_err    out  1  sticky: memory timeout
//  illegal    out  1  sticky: unknown opcode (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=FETCH, wait cnt=0, bus_err=illegal=0; while reset low every output is 0 (async, mid-instr abort).
//  Outputs combinational from state/OP/funct/Zero/mem_ready; unlisted outputs 0 in each state.
//  FETCH: MemRead=1 IorD=0 SrcA=0 SrcB=01 ALUOp=00 PCSource=00; on mem_ready: IRWrite=1 PCWrite=1 ->DECODE.
//  DECODE: SrcA=0 SrcB=11 EXTOp=01 ALUOp=00 (branch target ->ALUOut); ->EXEC for legal OP.
//  EXEC: R-type SrcA=1 SrcB=00, ALUOp funct 100001->00, 100011->01, other->00; ->WB.
//        ori SrcA=1 SrcB=10 EXTOp=00 ALUOp=10 ->WB.  lw/sw SrcA=1 SrcB=10 EXTOp=01 ALUOp=00 ->MEM.
//        beq SrcA=1 SrcB=00 ALUOp=01 PCSource=01 PCWrite=Zero ->FETCH.
//        jal PCSource=10 PCWrite=1 RegWrite=1 RegDst=10 Mem2Reg=10 (PC already +4) ->FETCH.
//  MEM: IorD=1; lw MemRead=1, sw MemWrite=1; on mem_ready lw->WB, sw->FETCH.
//  WB: RegWrite=1; R-type RegDst=01 Mem2Reg=00; ori RegDst=00 Mem2Reg=00; lw RegDst=00 Mem2Reg=01 ->FETCH.
//  Handshake: request held stable until mem_ready; mem_ready outside FETCH/MEM ignored; ready in the
//   first request cycle completes in that cycle (zero wait).
//  Timeout: cnt counts FETCH/MEM cycles with mem_ready=0, clears on state change; the cycle with
//   cnt==MEM_TIMEOUT-1 and no ready ->HALT, bus_err=1. Ready on that same cycle wins (normal advance).
//  HALT: all control outputs 0, flags hold, exit only by reset.
//  CPI (zero-wait): beq/jal 3, R/ori/sw 4, lw 5.
// CONFIGURATION
//  CTRL_ILLEGAL_TRAP_EN defined: unknown OP in DECODE ->HALT, illegal=1 sticky.
//  Undefined: unknown OP in DECODE ->FETCH (NOP, PC already advanced); illegal tied 0.
// TESTING
//  addu (OP=0 funct=100001), ready=1 always -> states 0,1,2,4; WB RegWrite=1 RegDst=01 Mem2Reg=00 ALUOp=00.
//  lw, ready low 3 MEM cycles -> MemRead=IorD=1 held 4 cycles, then WB Mem2Reg=01 RegDst=00; 8 cycles total.
//  beq Zero=1 -> EXEC PCWrite=1 PCSource=01 ->FETCH; Zero=0 -> PCWrite=0; 3 cycles each.
//  jal -> EXEC RegWrite=1 RegDst=10 Mem2Reg=10 PCWrite=1 PCSource=10; next state FETCH.
//  ready stuck 0 in FETCH, MEM_TIMEOUT=16 -> HALT after 16th cycle, bus_err=1; reset low mid-MEM -> outputs 0, FETCH.
//  OP=111111: macro on -> HALT, illegal=1; macro off -> FETCH, illegal=0, no writes.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer (master) and the MIPS datapath/memory (slave).
// Carries IR fields, ALU zero, memory ready, every datapath control strobe and the status flags.
interface multicycle_ctrl_if;
    logic [5:0] OP;
    logic [5:0] funct;
    logic       Zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       IRWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] Mem2Reg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic [1:0] EXTOp;
    logic [2:0] state;
    logic       bus_err;
    logic       illegal;

    modport master (
        input  OP, funct, Zero, mem_ready,
        output PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, Mem2Reg,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, EXTOp, state, bus_err, illegal
    );

    modport slave (
        output OP, funct, Zero, mem_ready,
        input  PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, Mem2Reg,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, EXTOp, state, bus_err, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS sequencer (addu/subu/ori/lw/sw/beq/jal); CTRL_ILLEGAL_TRAP_EN halts on unknown opcodes.
// Latency: 3 cycles beq/jal, 4 R/ori/sw, 5 lw at zero wait; controls are combinational from state.
// Backpressure: FETCH/MEM hold the request until mem_ready; MEM_TIMEOUT idle cycles -> HALT with bus_err.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master cif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             bus_err_q;
    logic             legal_op;
    logic             mem_wait;
    logic             mem_timeout;

    logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write, alu_src_a;
    logic [1:0] reg_dst, mem2reg, alu_src_b, alu_op, pc_source, ext_op;

    always_comb begin
        case (cif.OP)
            OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_JAL: legal_op = 1'b1;
            default:                                         legal_op = 1'b0;
        endcase
    end

    // Only FETCH and MEM own the memory; ready seen in any other state is ignored.
    assign mem_wait    = ((state_q == FETCH) || (state_q == MEM)) && !cif.mem_ready;
    assign mem_timeout = mem_wait && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        alu_src_a = 1'b0;
        reg_dst   = 2'b00;
        mem2reg   = 2'b00;
        alu_src_b = 2'b00;
        alu_op    = 2'b00;
        pc_source = 2'b00;
        ext_op    = 2'b00;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (cif.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else if (mem_timeout) begin
                    state_d = HALT;
                end
            end
            DECODE: begin
                // Speculatively form the branch target into ALUOut.
                alu_src_b = 2'b11;
                ext_op    = 2'b01;
`ifdef CTRL_ILLEGAL_TRAP_EN
                state_d   = legal_op ? EXEC : HALT;
`else
                state_d   = legal_op ? EXEC : FETCH;
`endif
            end
            EXEC: begin
                case (cif.OP)
                    OP_RTYPE: begin
                        alu_src_a = 1'b1;
                        alu_op    = (cif.funct == FN_SUBU) ? 2'b01 : 2'b00;
                        state_d   = WB;
                    end
                    OP_ORI: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        alu_op    = 2'b10;
                        state_d   = WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        ext_op    = 2'b01;
                        state_d   = MEM;
                    end
                    OP_BEQ: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b01;
                        pc_source = 2'b01;
                        pc_write  = cif.Zero;
                        state_d   = FETCH;
                    end
                    OP_JAL: begin
                        pc_source = 2'b10;
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                        reg_dst   = 2'b10;
                        mem2reg   = 2'b10;
                        state_d   = FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                iord = 1'b1;
                if (cif.OP == OP_LW) mem_read  = 1'b1;
                else                 mem_write = 1'b1;
                if (cif.mem_ready) begin
                    state_d = (cif.OP == OP_LW) ? WB : FETCH;
                end else if (mem_timeout) begin
                    state_d = HALT;
                end
            end
            WB: begin
                reg_write = 1'b1;
                case (cif.OP)
                    OP_RTYPE: reg_dst = 2'b01;
                    OP_LW:    mem2reg = 2'b01;
                    default:  reg_dst = 2'b00;
                endcase
                state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) cnt_q <= '0;
            else if (mem_wait)      cnt_q <= cnt_q + CNT_W'(1);
            if (mem_timeout) bus_err_q <= 1'b1;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                illegal_q <= 1'b0;
        else if (state_q == DECODE && !legal_op)   illegal_q <= 1'b1;
    end
    assign cif.illegal = illegal_q;
`else
    assign cif.illegal = 1'b0;
`endif

    // Gate strobes with reset so an abort mid-instruction drops every request immediately.
    assign cif.PCWrite  = reset & pc_write;
    assign cif.IRWrite  = reset & ir_write;
    assign cif.IorD     = reset & iord;
    assign cif.MemRead  = reset & mem_read;
    assign cif.MemWrite = reset & mem_write;
    assign cif.RegWrite = reset & reg_write;
    assign cif.ALUSrcA  = reset & alu_src_a;
    assign cif.RegDst   = {2{reset}} & reg_dst;
    assign cif.Mem2Reg  = {2{reset}} & mem2reg;
    assign cif.ALUSrcB  = {2{reset}} & alu_src_b;
    assign cif.ALUOp    = {2{reset}} & alu_op;
    assign cif.PCSource = {2{reset}} & pc_source;
    assign cif.EXTOp    = {2{reset}} & ext_op;
    assign cif.state    = state_q;
    assign cif.bus_err  = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each instruction class, memory waits, timeout and reset abort.
module tb_multicycle_ctrl;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    multicycle_ctrl_if cif();

    multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .cif   (cif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b0; cif.OP = 6'd0; cif.funct = 6'd0; cif.Zero = 1'b0; cif.mem_ready = 1'b1;
        tick();
        checks++; if (cif.state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", cif.state); end
        checks++; if (cif.MemRead !== 1'b0) begin errors++; $display("FAIL reset_memread got=%0b exp=0", cif.MemRead); end
        checks++; if (cif.ALUSrcB !== 2'b00) begin errors++; $display("FAIL reset_srcb got=%0b exp=00", cif.ALUSrcB); end
        checks++; if (cif.bus_err !== 1'b0 || cif.illegal !== 1'b0) begin errors++; $display("FAIL reset_flags got=%0b%0b exp=00", cif.bus_err, cif.illegal); end
        reset = 1'b1; #1;
        checks++; if (cif.MemRead !== 1'b1 || cif.ALUSrcB !== 2'b01) begin errors++; $display("FAIL release_fetch got=%0b/%0b exp=1/01", cif.MemRead, cif.ALUSrcB); end
    endtask

    task automatic test_addu();
        cif.OP = 6'b000000; cif.funct = 6'b100001; cif.mem_ready = 1'b1; #1;
        checks++; if (cif.IRWrite !== 1'b1 || cif.PCWrite !== 1'b1 || cif.IorD !== 1'b0) begin errors++; $display("FAIL addu_fetch got=%0b%0b%0b exp=110", cif.IRWrite, cif.PCWrite, cif.IorD); end
        tick();
        checks++; if (cif.state !== 3'd1) begin errors++; $display("FAIL addu_decode_state got=%0d exp=1", cif.state); end
        checks++; if (cif.ALUSrcB !== 2'b11 || cif.EXTOp !== 2'b01 || cif.MemRead !== 1'b0) begin errors++; $display("FAIL addu_decode_ctl got=%0b/%0b/%0b exp=11/01/0", cif.ALUSrcB, cif.EXTOp, cif.MemRead); end
        tick();
        checks++; if (cif.state !== 3'd2) begin errors++; $display("FAIL addu_exec_state got=%0d exp=2", cif.state); end
        checks++; if (cif.ALUSrcA !== 1'b1 || cif.ALUSrcB !== 2'b00 || cif.ALUOp !== 2'b00) begin errors++; $display("FAIL addu_exec_ctl got=%0b/%0b/%0b exp=1/00/00", cif.ALUSrcA, cif.ALUSrcB, cif.ALUOp); end
        tick();
        checks++; if (cif.state !== 3'd4) begin errors++; $display("FAIL addu_wb_state got=%0d exp=4", cif.state); end
        checks++; if (cif.RegWrite !== 1'b1 || cif.RegDst !== 2'b01 || cif.Mem2Reg !== 2'b00) begin errors++; $display("FAIL addu_wb_ctl got=%0b/%0b/%0b exp=1/01/00", cif.RegWrite, cif.RegDst, cif.Mem2Reg); end
        tick();
        checks++; if (cif.state !== 3'd0) begin errors++; $display("FAIL addu_end_state got=%0d exp=0", cif.state); end
    endtask

    task automatic test_subu();
        cif.OP = 6'b000000; cif.funct = 6'b100011; #1;
        tick(); tick();
        checks++; if (cif.ALUOp !== 2'b01) begin errors++; $display("FAIL subu_aluop got=%0b exp=01", cif.ALUOp); end
        tick(); tick();
        checks++; if (cif.state !== 3'd0) begin errors++; $display("FAIL subu_end_state got=%0d exp=0", cif.state); end
    endtask

    task automatic test_ori();
        cif.OP = 6'b001101; #1;
        tick(); tick();
        checks++; if (cif.ALUSrcB !== 2'b10 || cif.EXTOp !== 2'b00 || cif.ALUOp !== 2'b10) begin errors++; $display("FAIL ori_exec got=%0b/%0b/%0b exp=10/00/10", cif.ALUSrcB, cif.EXTOp, cif.ALUOp); end
        tick();
        checks++; if (cif.state !== 3'd4 || cif.RegDst !== 2'b00 || cif.RegWrite !== 1'b1) begin errors++; $display("FAIL ori_wb got=%0d/%0b/%0b exp=4/00/1", cif.state, cif.RegDst, cif.RegWrite); end
        tick();
    endtask

    task automatic test_lw_wait();
        cif.OP = 6'b100011; cif.mem_ready = 1'b1; #1;
        tick(); tick();
        checks++; if (cif.ALUSrcB !== 2'b10 || cif.EXTOp !== 2'b01) begin errors++; $display("FAIL lw_exec got=%0b/%0b exp=10/01", cif.ALUSrcB, cif.EXTOp); end
        cif.mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (cif.state !== 3'd3 || cif.MemRead !== 1'b1 || cif.IorD !== 1'b1) begin errors++; $display("FAIL lw_mem_wait%0d got=%0d/%0b/%0b exp=3/1/1", i, cif.state, cif.MemRead, cif.IorD); end
            tick();
        end
        cif.mem_ready = 1'b1; #1;
        checks++; if (cif.state !== 3'd3 || cif.MemRead !== 1'b1 || cif.IorD !== 1'b1) begin errors++; $display("FAIL lw_mem_done got=%0d/%0b/%0b exp=3/1/1", cif.state, cif.MemRead, cif.IorD); end
        tick();
        checks++; if (cif.state !== 3'd4 || cif.Mem2Reg !== 2'b01 || cif.RegDst !== 2'b00) begin errors++; $display("FAIL lw_wb got=%0d/%0b/%0b exp=4/01/00", cif.state, cif.Mem2Reg, cif.RegDst); end
        tick();
        checks++; if (cif.state !== 3'd0) begin errors++; $display("FAIL lw_end_state got=%0d exp=0", cif.state); end
    endtask

    task automatic test_sw();
        cif.OP = 6'b101011; #1;
        tick(); tick(); tick();
        checks++; if (cif.MemWrite !== 1'b1 || cif.MemRead !== 1'b0 || cif.IorD !== 1'b1) begin errors++; $display("FAIL sw_mem got=%0b/%0b/%0b exp=1/0/1", cif.MemWrite, cif.MemRead, cif.IorD); end
        tick();
        checks++; if (cif.state !== 3'd0) begin errors++; $display("FAIL sw_end_state got=%0d exp=0", cif.state); end
    endtask

    task automatic test_beq();
        cif.OP = 6'b000100; cif.Zero = 1'b1; #1;
        tick(); tick();
        checks++; if (cif.PCWrite !== 1'b1 || cif.PCSource !== 2'b01 || cif.ALUOp !== 2'b01) begin errors++; $display("FAIL beq_taken got=%0b/%0b/%0b exp=1/01/01", cif.PCWrite, cif.PCSource, cif.ALUOp); end
        tick();
        checks++; if (cif.state !== 3'd0) begin errors++; $display("FAIL beq_taken_end got=%0d exp=0", cif.state); end
        cif.Zero = 1'b0; #1;
        tick(); tick();
        checks++; if (cif.PCWrite !== 1'b0 || cif.state !== 3'd2) begin errors++; $display("FAIL beq_not_taken got=%0b/%0d exp=0/2", cif.PCWrite, cif.state); end
        tick();
        checks++; if (cif.state !== 3'd0) begin errors++; $display("FAIL beq_nt_end got=%0d exp=0", cif.state); end
    endtask

    task automatic test_jal();
        cif.OP = 6'b000011; #1;
        tick(); tick();
        checks++; if (cif.RegWrite !== 1'b1 || cif.RegDst !== 2'b10 || cif.Mem2Reg !== 2'b10) begin errors++; $display("FAIL jal_rf got=%0b/%0b/%0b exp=1/10/10", cif.RegWrite, cif.RegDst, cif.Mem2Reg); end
        checks++; if (cif.PCWrite !== 1'b1 || cif.PCSource !== 2'b10) begin errors++; $display("FAIL jal_pc got=%0b/%0b exp=1/10", cif.PCWrite, cif.PCSource); end
        tick();
        checks++; if (cif.state !== 3'd0) begin errors++; $display("FAIL jal_end_state got=%0d exp=0", cif.state); end
    endtask

    task automatic test_illegal();
        cif.OP = 6'b111111; #1;
        tick();
        checks++; if (cif.RegWrite !== 1'b0 || cif.PCWrite !== 1'b0 || cif.MemWrite !== 1'b0) begin errors++; $display("FAIL illegal_decode_writes got=%0b%0b%0b exp=000", cif.RegWrite, cif.PCWrite, cif.MemWrite); end
        tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
        checks++; if (cif.state !== 3'd5 || cif.illegal !== 1'b1) begin errors++; $display("FAIL illegal_trap got=%0d/%0b exp=5/1", cif.state, cif.illegal); end
        reset = 1'b0; #1;
        checks++; if (cif.state !== 3'd0 || cif.illegal !== 1'b0) begin errors++; $display("FAIL illegal_clear got=%0d/%0b exp=0/0", cif.state, cif.illegal); end
        reset = 1'b1;
`else
        checks++; if (cif.state !== 3'd0 || cif.illegal !== 1'b0) begin errors++; $display("FAIL illegal_nop got=%0d/%0b exp=0/0", cif.state, cif.illegal); end
`endif
    endtask

    task automatic test_reset_mid_mem();
        cif.OP = 6'b100011; cif.mem_ready = 1'b1; #1;
        tick(); tick(); tick();
        cif.mem_ready = 1'b0; #1;
        checks++; if (cif.state !== 3'd3 || cif.MemRead !== 1'b1) begin errors++; $display("FAIL abort_pre got=%0d/%0b exp=3/1", cif.state, cif.MemRead); end
        reset = 1'b0; #1;
        checks++; if (cif.state !== 3'd0 || cif.MemRead !== 1'b0 || cif.IorD !== 1'b0) begin errors++; $display("FAIL abort_outputs got=%0d/%0b/%0b exp=0/0/0", cif.state, cif.MemRead, cif.IorD); end
        reset = 1'b1; #1;
        checks++; if (cif.MemRead !== 1'b1 || cif.IorD !== 1'b0) begin errors++; $display("FAIL abort_refetch got=%0b/%0b exp=1/0", cif.MemRead, cif.IorD); end
    endtask

    task automatic test_timeout_ready_wins();
        cif.OP = 6'b000000; cif.funct = 6'b100001; cif.mem_ready = 1'b0;
        repeat (15) tick();
        checks++; if (cif.state !== 3'd0) begin errors++; $display("FAIL wins_pre got=%0d exp=0", cif.state); end
        cif.mem_ready = 1'b1;
        tick();
        checks++; if (cif.state !== 3'd1 || cif.bus_err !== 1'b0) begin errors++; $display("FAIL wins_advance got=%0d/%0b exp=1/0", cif.state, cif.bus_err); end
        tick(); tick(); tick();
        checks++; if (cif.state !== 3'd0) begin errors++; $display("FAIL wins_end got=%0d exp=0", cif.state); end
    endtask

    task automatic test_timeout();
        cif.mem_ready = 1'b0;
        repeat (15) tick();
        checks++; if (cif.state !== 3'd0 || cif.bus_err !== 1'b0) begin errors++; $display("FAIL timeout_pre got=%0d/%0b exp=0/0", cif.state, cif.bus_err); end
        tick();
        checks++; if (cif.state !== 3'd5 || cif.bus_err !== 1'b1) begin errors++; $display("FAIL timeout_halt got=%0d/%0b exp=5/1", cif.state, cif.bus_err); end
        checks++; if (cif.MemRead !== 1'b0 || cif.IRWrite !== 1'b0 || cif.ALUSrcB !== 2'b00) begin errors++; $display("FAIL halt_ctl got=%0b/%0b/%0b exp=0/0/00", cif.MemRead, cif.IRWrite, cif.ALUSrcB); end
        cif.mem_ready = 1'b1;
        tick();
        checks++; if (cif.state !== 3'd5 || cif.bus_err !== 1'b1) begin errors++; $display("FAIL halt_hold got=%0d/%0b exp=5/1", cif.state, cif.bus_err); end
        reset = 1'b0; #1;
        checks++; if (cif.state !== 3'd0 || cif.bus_err !== 1'b0) begin errors++; $display("FAIL halt_reset got=%0d/%0b exp=0/0", cif.state, cif.bus_err); end
        reset = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_addu();
        test_subu();
        test_ori();
        test_lw_wait();
        test_sw();
        test_beq();
        test_jal();
        test_illegal();
        test_reset_mid_mem();
        test_timeout_ready_wins();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
